// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP RGB565 transmitter.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_LINE,
    ST_HBLANK,
    ST_VFRONT
  } dvp_state_e;

  localparam logic [15:0] PAD_PIXEL       = 16'h0000;
  localparam bit          HIGH_BYTE_FIRST = 1'b1;
  localparam logic        VSYNC_IDLE      = 1'b1;

endpackage

// File: rtl/dvp_tx_timing.sv
// Byte-clock phase generator plus per-state byte counter and line counter.
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 120,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_SYNC   = 64,
  parameter int unsigned V_BACK   = 32,
  parameter int unsigned V_FRONT  = 32
) (
  input  logic       image_loader_clk,
  input  logic       reset,
  input  logic       enable,
  input  dvp_state_e state,
  output logic       phase,
  output logic       upd_slot,
  output logic       byte_odd,
  output logic       state_last_byte,
  output logic       last_line
);

  localparam int unsigned LINE_BYTES = 2 * H_ACTIVE;
  localparam int unsigned MAX_A      = (LINE_BYTES > H_BLANK) ? LINE_BYTES : H_BLANK;
  localparam int unsigned MAX_B      = (MAX_A > V_SYNC) ? MAX_A : V_SYNC;
  localparam int unsigned MAX_C      = (MAX_B > V_BACK) ? MAX_B : V_BACK;
  localparam int unsigned MAX_BYTES  = (MAX_C > V_FRONT) ? MAX_C : V_FRONT;
  localparam int unsigned BW         = $clog2(MAX_BYTES + 1);
  localparam int unsigned LW         = $clog2(V_ACTIVE + 1);

  logic [BW-1:0] byte_cnt;
  logic [BW-1:0] state_len;
  logic [LW-1:0] line_cnt;

  assign upd_slot        = enable & phase;
  assign byte_odd        = byte_cnt[0];
  assign state_last_byte = (byte_cnt == state_len - BW'(1));
  assign last_line       = (line_cnt == LW'(V_ACTIVE - 1));

  always_comb begin
    state_len = BW'(1);
    case (state)
      ST_VSYNC:  state_len = BW'(V_SYNC);
      ST_VBACK:  state_len = BW'(V_BACK);
      ST_LINE:   state_len = BW'(LINE_BYTES);
      ST_HBLANK: state_len = BW'(H_BLANK);
      ST_VFRONT: state_len = BW'(V_FRONT);
      default:   state_len = BW'(1);
    endcase
  end

  always_ff @(posedge image_loader_clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (enable) begin
      phase <= ~phase;
    end
  end

  // Every state exits on its last byte, so reloading there doubles as reload-on-entry.
  always_ff @(posedge image_loader_clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else if (upd_slot) begin
      byte_cnt <= state_last_byte ? '0 : byte_cnt + BW'(1);
      if (state == ST_IDLE) begin
        line_cnt <= '0;
      end else if (state == ST_HBLANK && state_last_byte && !last_line) begin
        line_cnt <= line_cnt + LW'(1);
      end
    end
  end

endmodule

// File: rtl/dvp_rgb565_transmitter.sv
// DVP camera-style source: serialises RGB565 pixels into bytes with href/vsynch framing.
module dvp_rgb565_transmitter
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 120,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_SYNC   = 64,
  parameter int unsigned V_BACK   = 32,
  parameter int unsigned V_FRONT  = 32
) (
  input  logic        image_loader_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        pclk_out,
  output logic        vsynch,
  output logic        href,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  dvp_state_e  state;
  dvp_state_e  state_nxt;
  logic        phase;
  logic        upd_slot;
  logic        byte_odd;
  logic        state_last_byte;
  logic        last_line;
  logic        start_pend;
  logic        start_acc;
  logic        fetch;
  logic [15:0] fetch_pix;
  logic [7:0]  lo_byte;

  dvp_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .image_loader_clk (image_loader_clk),
    .reset            (reset),
    .enable           (enable),
    .state            (state),
    .phase            (phase),
    .upd_slot         (upd_slot),
    .byte_odd         (byte_odd),
    .state_last_byte  (state_last_byte),
    .last_line        (last_line)
  );

  assign pclk_out  = phase;
  assign start_acc = enable && start && (state == ST_IDLE);

  always_ff @(posedge image_loader_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (upd_slot) begin
      state <= state_nxt;
    end
  end

  // Fetch when the byte about to be driven is the first byte of a pixel.
  always_comb begin
    state_nxt   = state;
    fetch       = 1'b0;
    pixel_ready = 1'b0;
    fetch_pix   = pixel_valid ? pixel_in : PAD_PIXEL;
    case (state)
      ST_IDLE:   if (start_pend) state_nxt = ST_VSYNC;
      ST_VSYNC:  if (state_last_byte) state_nxt = ST_VBACK;
      ST_VBACK:  if (state_last_byte) state_nxt = ST_LINE;
      ST_LINE:   if (state_last_byte) state_nxt = ST_HBLANK;
      ST_HBLANK: if (state_last_byte) state_nxt = last_line ? ST_VFRONT : ST_LINE;
      ST_VFRONT: if (state_last_byte) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    fetch       = upd_slot && (state_nxt == ST_LINE) && ((state != ST_LINE) || byte_odd);
    pixel_ready = fetch;
  end

  always_ff @(posedge image_loader_clk or posedge reset) begin
    if (reset) begin
      start_pend <= 1'b0;
      href       <= 1'b0;
      vsynch     <= VSYNC_IDLE;
      data_out   <= 8'h00;
      lo_byte    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= upd_slot && (state == ST_VFRONT) && state_last_byte;
      if (upd_slot && (state == ST_IDLE) && start_pend) begin
        start_pend <= 1'b0;
      end else if (start_acc) begin
        start_pend <= 1'b1;
      end
      if (start_acc) begin
        underflow <= 1'b0;
      end else if (fetch && !pixel_valid) begin
        underflow <= 1'b1;
      end
      if (upd_slot) begin
        busy   <= (state_nxt != ST_IDLE);
        vsynch <= (state_nxt == ST_IDLE || state_nxt == ST_VSYNC) ? VSYNC_IDLE : ~VSYNC_IDLE;
        href   <= (state_nxt == ST_LINE);
        if (fetch) begin
          data_out <= HIGH_BYTE_FIRST ? fetch_pix[15:8] : fetch_pix[7:0];
          lo_byte  <= HIGH_BYTE_FIRST ? fetch_pix[7:0] : fetch_pix[15:8];
        end else if (state_nxt == ST_LINE) begin
          data_out <= lo_byte;
        end else begin
          data_out <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_transmitter.sv
// Scoreboard bench for dvp_rgb565_transmitter: random pixel frames against a byte-stream model.
`timescale 1ns/1ps
module tb_dvp_rgb565_transmitter;

  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int H_BLANK     = 2;
  localparam int V_SYNC      = 3;
  localparam int V_BACK      = 2;
  localparam int V_FRONT     = 2;
  localparam int FRAME_BYTES = V_SYNC + V_BACK + V_ACTIVE * (2 * H_ACTIVE + H_BLANK) + V_FRONT;
  localparam int NPIX        = H_ACTIVE * V_ACTIVE;
  localparam int BUDGET      = 4000;

  logic        image_loader_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pclk_out;
  logic        vsynch;
  logic        href;
  logic [7:0]  data_out;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  dvp_rgb565_transmitter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) dut (
    .image_loader_clk (image_loader_clk),
    .reset            (reset),
    .enable           (enable),
    .start            (start),
    .pixel_in         (pixel_in),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .pclk_out         (pclk_out),
    .vsynch           (vsynch),
    .href             (href),
    .data_out         (data_out),
    .busy             (busy),
    .frame_done       (frame_done),
    .underflow        (underflow)
  );

  always #5 image_loader_clk = ~image_loader_clk;

  logic [15:0] plan_pix[$];
  bit          plan_val[$];
  logic [7:0]  exp_q[$];
  int          src_idx;
  int          n_checks;
  int          n_pass;
  int          frame_cycles;
  int          rises;
  int          href_cycles;
  int          fetches;
  int          hs;
  int          done_cnt;
  logic        prev_pclk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
  endtask

  // Reference model: high byte then low byte of each pixel; a starved fetch yields two zero bytes.
  task automatic add_pixel(input logic [15:0] p, input bit v);
    plan_pix.push_back(p);
    plan_val.push_back(v);
    exp_q.push_back(v ? p[15:8] : 8'h00);
    exp_q.push_back(v ? p[7:0] : 8'h00);
  endtask

  task automatic plan_frame(input int bad);
    for (int i = 0; i < NPIX; i++) add_pixel(16'($urandom), i != bad);
  endtask

  task automatic tick();
    @(posedge image_loader_clk);
    #1;
  endtask

  task automatic clear_stats();
    frame_cycles = 0;
    rises        = 0;
    href_cycles  = 0;
    fetches      = 0;
    hs           = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_en);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      if (rand_en) enable = ($urandom_range(3) != 0);
    end
    enable = 1'b1;
    if (!ok) begin
      n_checks++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", BUDGET);
    end
  endtask

  task automatic check_frame(input int nbad);
    check("frame_cycles", frame_cycles, 2 * FRAME_BYTES);
    check("pclk_rises", rises, FRAME_BYTES);
    check("href_cycles", href_cycles, V_ACTIVE * 4 * H_ACTIVE);
    check("fetches", fetches, NPIX);
    check("handshakes", hs, NPIX - nbad);
    check("bytes_left", exp_q.size(), 0);
    check("underflow_end", int'(underflow), int'(nbad > 0));
    check("done_state", int'({busy, href, vsynch}), 1);
  endtask

  // Pixel source: presents the planned pixels in order, advancing on each fetch strobe.
  initial begin
    bit adv;
    pixel_in    = 16'h0000;
    pixel_valid = 1'b0;
    src_idx     = 0;
    forever begin
      @(negedge image_loader_clk);
      adv = pixel_ready;
      @(posedge image_loader_clk);
      #1;
      if (adv) src_idx++;
      if (src_idx < plan_pix.size()) begin
        pixel_in    = plan_pix[src_idx];
        pixel_valid = plan_val[src_idx];
      end else begin
        pixel_in    = 16'hEEEE;
        pixel_valid = 1'b1;
      end
    end
  end

  // Receiver monitor: samples a byte on every pclk_out rising edge while href is high.
  initial begin
    prev_pclk = 1'b0;
    done_cnt  = 0;
    forever begin
      @(negedge image_loader_clk);
      if (!reset) begin
        if (busy && enable) frame_cycles++;
        if (href && enable) href_cycles++;
        if (pixel_ready) begin
          fetches++;
          if (pixel_valid) hs++;
        end
        if (frame_done) done_cnt++;
        if (pclk_out && !prev_pclk && busy) begin
          rises++;
          if (href) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL byte_extra: got %02h, nothing expected at %0t", data_out, $time);
            end else begin
              check("byte", int'(data_out), int'(exp_q.pop_front()));
            end
          end
        end
      end
      prev_pclk = pclk_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dir_pix[NPIX];
    logic        hold_pclk;
    logic [7:0]  hold_data;
    logic        prev_href;
    int          nh;
    int          d0;
    int          bad;
    bit          seen;

    dir_pix = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    repeat (3) tick();
    check("rst_pclk", int'(pclk_out), 0);
    check("rst_vsynch", int'(vsynch), 1);
    check("rst_href", int'(href), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_ready", int'(pixel_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_underflow", int'(underflow), 0);
    reset = 1'b0;
    tick();

    // Directed frame with a known pixel stream.
    for (int i = 0; i < NPIX; i++) add_pixel(dir_pix[i], 1'b1);
    clear_stats();
    pulse_start();
    wait_done(1'b0);
    check_frame(0);

    // Third fetch starved.
    plan_frame(2);
    clear_stats();
    pulse_start();
    wait_done(1'b0);
    check_frame(1);
    repeat (5) tick();
    check("underflow_sticky", int'(underflow), 1);

    // Next start clears underflow; random enable throttling.
    plan_frame(-1);
    clear_stats();
    pulse_start();
    tick();
    check("underflow_cleared", int'(underflow), 0);
    wait_done(1'b1);
    check_frame(0);

    // Start in the frame_done cycle, then a start while busy.
    plan_frame(-1);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_not_yet", int'(busy), 0);
    tick();
    check("b2b_busy", int'(busy), 1);
    repeat (20) tick();
    pulse_start();
    wait_done(1'b0);
    check_frame(0);
    d0 = done_cnt;
    repeat (60) tick();
    check("single_done", done_cnt, d0 + 1);
    check("idle_after", int'(busy), 0);

    // Enable gap mid-line.
    plan_frame(-1);
    clear_stats();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (href) begin
        seen = 1'b1;
        break;
      end
    end
    check("href_seen", int'(seen), 1);
    repeat (3) tick();
    enable    = 1'b0;
    hold_pclk = pclk_out;
    hold_data = data_out;
    repeat (7) tick();
    check("gap_pclk_hold", int'(pclk_out), int'(hold_pclk));
    check("gap_data_hold", int'(data_out), int'(hold_data));
    enable = 1'b1;
    wait_done(1'b0);
    check_frame(0);

    // Reset during the second line.
    plan_frame(-1);
    clear_stats();
    pulse_start();
    nh        = 0;
    prev_href = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (href && !prev_href) nh++;
      prev_href = href;
      if (nh == 2) break;
    end
    check("line2_reached", nh, 2);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_href", int'(href), 0);
    check("mid_rst_vsynch", int'(vsynch), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(data_out), 0);
    check("mid_rst_pclk", int'(pclk_out), 0);
    tick();
    @(posedge image_loader_clk);
    #3;
    exp_q.delete();
    src_idx = plan_pix.size();
    reset   = 1'b0;
    tick();
    plan_frame(-1);
    clear_stats();
    pulse_start();
    wait_done(1'b0);
    check_frame(0);

    // Randomized frames with random starvation and enable throttling.
    for (int f = 0; f < 4; f++) begin
      bad = int'($urandom_range(NPIX));
      plan_frame(bad);
      clear_stats();
      pulse_start();
      wait_done(1'b1);
      check_frame((bad < NPIX) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
